vga_timing_gen: RTL



---
 rtl/vga_timing_gen_if.sv | 19 +
 rtl/vga_timing_gen.sv | 113 +++++++++++
 2 files changed

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: raster timing outputs of vga_timing_gen.
// master = timing generator, slave = render stages / VGA connector.
interface vga_timing_gen_if;
  logic       hs;
  logic       vs;
  logic       blank;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       frame_start;
  logic [7:0] frame_cnt;

  modport master (
    output hs, vs, blank, DrawX, DrawY, frame_start, frame_cnt
  );

  modport slave (
    input hs, vs, blank, DrawX, DrawY, frame_start, frame_cnt
  );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 Hz raster timing from the 25 MHz pixel clock.
// Optional macro VGA_SYNC_ALIGN_EN delays hs/vs by two cycles to match the
// downstream ROM lookup plus colour output register.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  vga_timing_gen_if.master  vga
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEGIN = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEGIN = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic       blank_q, blank_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       frame_start_q, frame_start_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic       h_wrap;
  logic       v_wrap;

  // Next counter state; decodes are taken from the next counter values so
  // the registered decodes line up with DrawX/DrawY with no skew.
  always_comb begin
    h_wrap  = (h_cnt_q == H_LAST);
    v_wrap  = (v_cnt_q == V_LAST);
    h_cnt_d = h_wrap ? '0 : h_cnt_q + 10'd1;
    v_cnt_d = v_cnt_q;
    if (h_wrap) begin
      v_cnt_d = v_wrap ? '0 : v_cnt_q + 10'd1;
    end
    blank_d       = (h_cnt_d < H_ACT) && (v_cnt_d < V_ACT);
    hs_d          = !((h_cnt_d >= HS_BEGIN) && (h_cnt_d < HS_END));
    vs_d          = !((v_cnt_d >= VS_BEGIN) && (v_cnt_d < VS_END));
    frame_start_d = h_wrap && v_wrap;
    frame_cnt_d   = frame_cnt_q + {7'd0, frame_start_d};
  end

  // Counter and decode registers.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      blank_q       <= 1'b1;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      blank_q       <= blank_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

`ifdef VGA_SYNC_ALIGN_EN
  logic [1:0] hs_pipe_q, hs_pipe_d;
  logic [1:0] vs_pipe_q, vs_pipe_d;

  // Two-stage sync delay shift.
  always_comb begin
    hs_pipe_d = {hs_pipe_q[0], hs_q};
    vs_pipe_d = {vs_pipe_q[0], vs_q};
  end

  // Sync delay registers, idle high.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_pipe_q <= '1;
      vs_pipe_q <= '1;
    end else begin
      hs_pipe_q <= hs_pipe_d;
      vs_pipe_q <= vs_pipe_d;
    end
  end

  assign vga.hs = hs_pipe_q[1];
  assign vga.vs = vs_pipe_q[1];
`else
  assign vga.hs = hs_q;
  assign vga.vs = vs_q;
`endif

  assign vga.blank       = blank_q;
  assign vga.DrawX       = h_cnt_q;
  assign vga.DrawY       = v_cnt_q;
  assign vga.frame_start = frame_start_q;
  assign vga.frame_cnt   = frame_cnt_q;

endmodule
